booth_datapath: RTL and testbench

- Register/arithmetic datapath for the radix-2 Booth sequential multiplier.
- Sits directly downstream of the Booth control FSM. Consumes LM, LA1/LA0, LQ1/LQ0 and AS; returns Q0 and Qm1 so the FSM can make its add/sub/shift decisions.
- Holds the multiplicand register M, accumulator A, multiplier/product-low register Q, and the Qm1 flop.
- Presents the {A,Q} product.

---
 rtl/booth_datapath.sv | 76 +++++++
 tb/tb_booth_datapath.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/booth_datapath.sv
// Register/arithmetic datapath for a radix-2 Booth sequential multiplier.
// Holds M, A, Q and Qm1; all control decisions come from an external FSM.
module booth_datapath #(
   parameter int N = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           LM,
   input  logic           LA1,
   input  logic           LA0,
   input  logic           LQ1,
   input  logic           LQ0,
   input  logic           AS,
   input  logic [N-1:0]   multiplicand_in,
   input  logic [N-1:0]   multiplier_in,
   output logic           Q0,
   output logic           Qm1,
   output logic [N-1:0]   A_out,
   output logic [2*N-1:0] product
);

   logic [N-1:0] m_reg;
   logic [N-1:0] a_reg;
   logic [N-1:0] q_reg;
   logic         qm1_reg;
   logic [N-1:0] sum;

   // Add/sub always works on the pre-edge M, even when M is reloaded this cycle.
   always_comb begin
      sum = AS ? (a_reg - m_reg) : (a_reg + m_reg);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         m_reg   <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         qm1_reg <= 1'b0;
      end else begin
         if (LM) m_reg <= multiplicand_in;

         case ({LA1, LA0})
            2'b01:   a_reg <= sum;
            2'b10:   a_reg <= {a_reg[N-1], a_reg[N-1:1]};
            2'b11:   a_reg <= '0;
            default: a_reg <= a_reg;
         endcase

         // Shift takes the old A[0], so add+shift in one cycle never sees the sum.
         case ({LQ1, LQ0})
            2'b01: begin
               q_reg   <= multiplier_in;
               qm1_reg <= 1'b0;
            end
            2'b10: begin
               q_reg   <= {a_reg[0], q_reg[N-1:1]};
               qm1_reg <= q_reg[0];
            end
            2'b11: begin
               q_reg   <= '0;
               qm1_reg <= 1'b0;
            end
            default: begin
               q_reg   <= q_reg;
               qm1_reg <= qm1_reg;
            end
         endcase
      end
   end

   assign Q0      = q_reg[0];
   assign Qm1     = qm1_reg;
   assign A_out   = a_reg;
   assign product = {a_reg, q_reg};

endmodule

// File: tb/tb_booth_datapath.sv
// Scoreboard bench for booth_datapath: a driver pushes expected register state,
// a negedge monitor pops and compares; final products are checked against plain multiplication.
module tb_booth_datapath;
   localparam int N = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic           LM, LA1, LA0, LQ1, LQ0, AS;
   logic [N-1:0]   multiplicand_in, multiplier_in;
   logic           Q0, Qm1;
   logic [N-1:0]   A_out;
   logic [2*N-1:0] product;

   booth_datapath #(.N(N)) dut (
      .clock(clock), .reset(reset), .LM(LM), .LA1(LA1), .LA0(LA0),
      .LQ1(LQ1), .LQ0(LQ0), .AS(AS),
      .multiplicand_in(multiplicand_in), .multiplier_in(multiplier_in),
      .Q0(Q0), .Qm1(Qm1), .A_out(A_out), .product(product)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   q;
      logic           qm1;
      logic           chk_prod;
      logic [2*N-1:0] prod;
      string          name;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state
   logic [N-1:0] mm, ma, mq;
   logic         mqm1;

   task automatic cyc(input bit rst, input bit lm, input logic [1:0] la,
                      input logic [1:0] lq, input bit as_sel,
                      input logic [N-1:0] mc, input logic [N-1:0] mp,
                      input string nm, input bit cp = 1'b0,
                      input logic [2*N-1:0] pv = '0);
      exp_t e;
      logic [N-1:0] na, nq, nm_v;
      logic         nqm;
      @(negedge clock);
      reset = rst; LM = lm; {LA1, LA0} = la; {LQ1, LQ0} = lq; AS = as_sel;
      multiplicand_in = mc; multiplier_in = mp;
      if (rst) begin
         nm_v = '0; na = '0; nq = '0; nqm = 1'b0;
      end else begin
         nm_v = lm ? mc : mm;
         case (la)
            2'd1:    na = as_sel ? N'(ma - mm) : N'(ma + mm);
            2'd2:    na = N'($signed(ma) >>> 1);
            2'd3:    na = '0;
            default: na = ma;
         endcase
         nq = mq; nqm = mqm1;
         case (lq)
            2'd1: begin nq = mp; nqm = 1'b0; end
            2'd2: begin nq = N'((mq >> 1) | (N'(ma[0]) << (N-1))); nqm = mq[0]; end
            2'd3: begin nq = '0; nqm = 1'b0; end
            default: ;
         endcase
      end
      mm = nm_v; ma = na; mq = nq; mqm1 = nqm;
      @(posedge clock);
      #1;
      e.a = ma; e.q = mq; e.qm1 = mqm1; e.chk_prod = cp; e.prod = pv; e.name = nm;
      sbq.push_back(e);
   endtask

   // Booth multiply driven from the model's view of Q0/Qm1; stops after 'iters' iterations.
   task automatic booth_mul(input logic [N-1:0] mc, input logic [N-1:0] mp,
                            input int iters, input string nm);
      logic signed [2*N-1:0] p;
      p = $signed(mc) * $signed(mp);
      cyc(0, 1, 2'b11, 2'b01, 0, mc, mp, {nm, "_init"});
      for (int i = 0; i < iters; i++) begin
         if ({mq[0], mqm1} == 2'b01) cyc(0, 0, 2'b01, 2'b00, 0, '0, '0, {nm, "_add"});
         else if ({mq[0], mqm1} == 2'b10) cyc(0, 0, 2'b01, 2'b00, 1, '0, '0, {nm, "_sub"});
         cyc(0, 0, 2'b10, 2'b10, 0, '0, '0, {nm, "_shift"},
             (iters == N) && (i == N-1), p);
      end
   endtask

   always @(negedge clock) begin
      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         tests++;
         if (A_out !== e.a || product !== {e.a, e.q} || Q0 !== e.q[0] || Qm1 !== e.qm1) begin
            fails++;
            $display("FAIL %s: got A=%h Q=%h Q0=%b Qm1=%b, want A=%h Q=%h Q0=%b Qm1=%b",
                     e.name, A_out, product[N-1:0], Q0, Qm1, e.a, e.q, e.q[0], e.qm1);
         end
         if (e.chk_prod) begin
            tests++;
            if (product !== e.prod) begin
               fails++;
               $display("FAIL %s_product: got %h, want %h", e.name, product, e.prod);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] r_mc, r_mp;
      mm = '0; ma = '0; mq = '0; mqm1 = 1'b0;
      reset = 1'b1; LM = 0; LA1 = 0; LA0 = 0; LQ1 = 0; LQ0 = 0; AS = 0;
      multiplicand_in = '0; multiplier_in = '0;

      cyc(1, 0, 2'b00, 2'b00, 0, '0, '0, "reset_init");

      // Preload nonzero, then reset with conflicting controls
      cyc(0, 1, 2'b00, 2'b01, 0, 4'h5, 4'h9, "preload");
      cyc(0, 0, 2'b01, 2'b00, 0, '0, '0, "preload_add");
      cyc(1, 1, 2'b01, 2'b10, 1, 4'h7, 4'h3, "reset_override");

      booth_mul(4'b0011, 4'b1110, N, "m3xn2");
      booth_mul(4'b0111, 4'b0111, N, "m7x7");
      booth_mul(4'b1101, 4'b1011, N, "mn3xn5");

      for (int i = 0; i < 5; i++) cyc(0, 0, 2'b00, 2'b00, 0, 4'hF, 4'hF, "hold");

      booth_mul(4'b0011, 4'b0101, 0, "prio");
      cyc(0, 0, 2'b01, 2'b00, 0, '0, '0, "prio_add");
      cyc(0, 0, 2'b01, 2'b10, 0, '0, '0, "add_with_shift");
      cyc(0, 1, 2'b01, 2'b00, 0, 4'h6, '0, "lm_with_add");
      cyc(0, 0, 2'b01, 2'b00, 1, '0, '0, "sub_new_m");

      booth_mul(4'b0011, 4'b1110, 2, "abort");
      cyc(1, 0, 2'b00, 2'b00, 0, '0, '0, "reset_midop");
      booth_mul(4'b0010, 4'b0011, N, "m2x3");

      for (int k = 0; k < 40; k++) begin
         do r_mc = N'($urandom); while (r_mc == 4'b1000);
         r_mp = N'($urandom);
         booth_mul(r_mc, r_mp, N, "rand_mul");
      end

      for (int k = 0; k < 60; k++)
         cyc(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), N'($urandom), N'($urandom), "rand_ctl");

      @(negedge clock);
      @(negedge clock);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
